// File: rtl/conv_pkg.sv
// Shared definitions for the conv-result max-pooling block: default widths and FSM encoding.
package conv_pkg;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous output FIFO carrying pooled data plus a row-end flag; supports push and pop together.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              head_last,
    output logic              full,
    output logic              empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [DATA_W:0]   mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [DATA_W:0]   hold;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                hold   <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= {push_last, push_data};
        end
    end

    // When empty, the output keeps presenting the most recently consumed entry.
    assign {head_last, head_data} = empty ? hold : mem[rd_ptr];

endmodule

// File: rtl/conv_maxpool.sv
// Thresholded activation followed by windowed max pooling into an output FIFO.
module conv_maxpool #(
    parameter int DATA_W     = conv_pkg::DATA_W,
    parameter int FIFO_DEPTH = conv_pkg::FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [2:0]        pool_win,
    input  logic [DATA_W-1:0] thresh,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              overflow
);

    import conv_pkg::*;

    function automatic logic [DATA_W-1:0] max_u(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] y);
        return (x > y) ? x : y;
    endfunction

    function automatic logic [DATA_W-1:0] act_floor(input logic [DATA_W-1:0] d,
                                                    input logic [DATA_W-1:0] t);
        return (d < t) ? '0 : d;
    endfunction

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        cnt_inc;
    logic [DATA_W-1:0] max_q, max_d;
    logic [2:0]        win_q, win_d;
    logic [DATA_W-1:0] thr_q, thr_d;
    logic [2:0]        eff_win;
    logic [DATA_W-1:0] act;
    logic              push;
    logic              push_en;
    logic [DATA_W-1:0] push_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              overflow_q;

    // Window settings come live from the ports when opening, from the latched copies inside a window.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        max_d     = max_q;
        win_d     = win_q;
        thr_d     = thr_q;
        push      = 1'b0;
        eff_win   = (pool_win == 3'd0) ? 3'd1 : pool_win;
        cnt_inc   = cnt_q + 3'd1;
        act       = act_floor(in_data, (state_q == IDLE) ? thresh : thr_q);
        push_data = act;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    win_d = eff_win;
                    thr_d = thresh;
                    max_d = act;
                    cnt_d = 3'd1;
                    if (eff_win == 3'd1 || in_last) begin
                        push = 1'b1;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            ACC: begin
                push_data = max_u(max_q, act);
                if (in_valid) begin
                    max_d = push_data;
                    cnt_d = cnt_inc;
                    if (cnt_inc == win_q || in_last) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A strobe arriving together with reset is discarded.
    assign push_en = push && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            max_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            max_q      <= max_d;
            overflow_q <= overflow_q | (push && fifo_full && !out_ready);
        end
    end

    always_ff @(posedge clk) begin
        win_q <= win_d;
        thr_q <= thr_d;
    end

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_en),
        .push_data (push_data),
        .push_last (in_last),
        .pop       (out_ready),
        .head_data (out_data),
        .head_last (out_last),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_conv_maxpool.sv
// Scoreboard bench for conv_maxpool: expected pooled results queued at stimulus time, checked at the FIFO head.
module tb_conv_maxpool;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic [2:0]    pool_win;
    logic [DW-1:0] thresh;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          overflow;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    conv_maxpool #(.DATA_W(DW), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .pool_win  (pool_win),
        .thresh    (thresh),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic l);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 8'd0, 0);
        drive(0, 8'd0, 0);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_checks++;
        if (out_data !== 8'd0) begin n_fail++; $display("FAIL reset_data: got %0d want 0", out_data); end
        n_checks++;
        if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", out_last); end
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        rst = 1'b0;
        drive(0, 8'd0, 0);
    endtask

    task automatic test_pool2();
        logic [DW-1:0] d [4];
        d = '{8'd3, 8'd9, 8'd4, 8'd1};
        pool_win = 3'd2; thresh = 8'd0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) exp_q.push_back('{8'd9, 1'b0});
            if (i == 3) exp_q.push_back('{8'd4, 1'b1});
            drive(1, d[i], i == 3);
            n_checks++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (out_valid !== 1'b1 || out_data !== e.data || out_last !== e.last) begin
                    n_fail++;
                    $display("FAIL pool2[%0d]: got v=%b d=%0d l=%b want v=1 d=%0d l=%b", i, out_valid, out_data, out_last, e.data, e.last);
                end
            end else if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL pool2_idle[%0d]: got valid=%b want 0", i, out_valid);
            end
        end
        drive(0, 8'd0, 0);
    endtask

    task automatic test_thresh();
        logic [DW-1:0] d [6];
        d = '{8'd2, 8'd4, 8'd7, 8'd2, 8'd4, 8'd3};
        pool_win = 3'd3; thresh = 8'd5; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) exp_q.push_back('{8'd7, 1'b0});
            if (i == 5) exp_q.push_back('{8'd0, 1'b0});
            drive(1, d[i], 0);
            // Settings changed mid-window must not affect the window already open.
            if (i == 3) begin pool_win = 3'd1; thresh = 8'd0; end
            n_checks++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (out_valid !== 1'b1 || out_data !== e.data || out_last !== e.last) begin
                    n_fail++;
                    $display("FAIL thresh[%0d]: got v=%b d=%0d l=%b want v=1 d=%0d l=%b", i, out_valid, out_data, out_last, e.data, e.last);
                end
            end else if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL thresh_idle[%0d]: got valid=%b want 0", i, out_valid);
            end
        end
        drive(0, 8'd0, 0);
    endtask

    task automatic test_partial();
        logic [DW-1:0] d [3];
        logic          l [3];
        d = '{8'd6, 8'd8, 8'd2};
        l = '{1'b0, 1'b1, 1'b0};
        pool_win = 3'd3; thresh = 8'd0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) exp_q.push_back('{8'd8, 1'b1});
            // A fresh single-entry window only yields 2 if the FSM returned to IDLE.
            if (i == 2) begin pool_win = 3'd1; exp_q.push_back('{8'd2, 1'b0}); end
            drive(1, d[i], l[i]);
            n_checks++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (out_valid !== 1'b1 || out_data !== e.data || out_last !== e.last) begin
                    n_fail++;
                    $display("FAIL partial[%0d]: got v=%b d=%0d l=%b want v=1 d=%0d l=%b", i, out_valid, out_data, out_last, e.data, e.last);
                end
            end else if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL partial_idle[%0d]: got valid=%b want 0", i, out_valid);
            end
        end
        drive(0, 8'd0, 0);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] v;
        logic [DW-1:0] a;
        logic [DW-1:0] m;
        pool_win = 3'd2; thresh = 8'd50; out_ready = 1'b1;
        m = '0;
        for (int i = 0; i < 16; i++) begin
            v = DW'($urandom_range(0, 255));
            a = (v < 8'd50) ? 8'd0 : v;
            if (i % 2 == 0) m = a;
            else begin
                if (a > m) m = a;
                exp_q.push_back('{m, i == 15});
            end
            drive(1, v, i == 15);
            n_checks++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (out_valid !== 1'b1 || out_data !== e.data || out_last !== e.last) begin
                    n_fail++;
                    $display("FAIL b2b[%0d]: got v=%b d=%0d l=%b want v=1 d=%0d l=%b", i, out_valid, out_data, out_last, e.data, e.last);
                end
            end else if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_idle[%0d]: got valid=%b want 0", i, out_valid);
            end
        end
        // pool_win of 0 behaves as a single-entry window.
        pool_win = 3'd0; thresh = 8'd0;
        for (int i = 0; i < 3; i++) begin
            v = DW'(8'd100 + 8'(i));
            exp_q.push_back('{v, 1'b0});
            drive(1, v, 0);
            e = exp_q.pop_front();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== e.data || out_last !== e.last) begin
                n_fail++;
                $display("FAIL win0[%0d]: got v=%b d=%0d l=%b want v=1 d=%0d l=%b", i, out_valid, out_data, out_last, e.data, e.last);
            end
        end
        drive(0, 8'd0, 0);
    endtask

    task automatic test_overflow();
        pool_win = 3'd1; thresh = 8'd0; out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            if (exp_q.size() < 4) exp_q.push_back('{DW'(i), 1'b0});
            drive(1, DW'(i), 0);
            n_checks++;
            if (overflow !== (i >= 5)) begin
                n_fail++;
                $display("FAIL ovf_flag[%0d]: got %b want %b", i, overflow, (i >= 5));
            end
        end
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'd1) begin
            n_fail++;
            $display("FAIL ovf_head: got v=%b d=%0d want v=1 d=1", out_valid, out_data);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== e.data || out_last !== e.last) begin
                n_fail++;
                $display("FAIL ovf_drain[%0d]: got v=%b d=%0d l=%b want v=1 d=%0d l=%b", k, out_valid, out_data, out_last, e.data, e.last);
            end
            drive(0, 8'd0, 0);
        end
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 8'd4) begin
            n_fail++;
            $display("FAIL ovf_empty: got v=%b d=%0d want v=0 d=4", out_valid, out_data);
        end
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_full_pushpop();
        logic [DW-1:0] d [4];
        d = '{8'd10, 8'd20, 8'd30, 8'd40};
        rst = 1'b1;
        drive(0, 8'd0, 0);
        rst = 1'b0;
        exp_q.delete();
        pool_win = 3'd1; thresh = 8'd0; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{d[i], 1'b0});
            drive(1, d[i], 0);
        end
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== exp_q[0].data) begin
            n_fail++;
            $display("FAIL full_head: got v=%b d=%0d want v=1 d=%0d", out_valid, out_data, exp_q[0].data);
        end
        out_ready = 1'b1;
        void'(exp_q.pop_front());
        exp_q.push_back('{8'h55, 1'b0});
        drive(1, 8'h55, 0);
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_pp_ovf: got %b want 0", overflow); end
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== e.data || out_last !== e.last) begin
                n_fail++;
                $display("FAIL full_pp_drain[%0d]: got v=%b d=%0d l=%b want v=1 d=%0d l=%b", k, out_valid, out_data, out_last, e.data, e.last);
            end
            drive(0, 8'd0, 0);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_pp_count: got valid=%b want 0 after 4 pops", out_valid); end
    endtask

    task automatic test_reset_midwindow();
        logic [DW-1:0] d [3];
        d = '{8'd1, 8'd2, 8'd3};
        pool_win = 3'd1; thresh = 8'd0; out_ready = 1'b0;
        drive(1, 8'd77, 0);
        pool_win = 3'd3;
        drive(1, 8'd9, 0);
        drive(1, 8'd8, 0);
        rst = 1'b1;
        drive(1, 8'd200, 0);
        rst = 1'b0;
        exp_q.delete();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 8'd0 || out_last !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: got v=%b d=%0d l=%b o=%b want 0 0 0 0", out_valid, out_data, out_last, overflow);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) exp_q.push_back('{8'd3, 1'b0});
            drive(1, d[i], 0);
            n_checks++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (out_valid !== 1'b1 || out_data !== e.data || out_last !== e.last) begin
                    n_fail++;
                    $display("FAIL rst_after[%0d]: got v=%b d=%0d l=%b want v=1 d=%0d l=%b", i, out_valid, out_data, out_last, e.data, e.last);
                end
            end else if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_after_idle[%0d]: got valid=%b want 0", i, out_valid);
            end
        end
        drive(0, 8'd0, 0);
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
        pool_win = 3'd1; thresh = '0; out_ready = 1'b0;
        test_reset();
        test_pool2();
        test_thresh();
        test_partial();
        test_back_to_back();
        test_overflow();
        test_full_pushpop();
        test_reset_midwindow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
